// File: rtl/vga_mem_arb.sv
// Arbitrates one synchronous single-port video RAM between display scan-out reads
// (priority) and a host read/write port. Optional macro: VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arb #(
    parameter int AW         = 12,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic [DW-1:0] disp_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, D_ISSUE, D_DATA, H_ISSUE, H_DATA} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          disp_ack_q, disp_ack_d;
    logic [DW-1:0] disp_rdata_q, disp_rdata_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          starve_full;
    logic          host_win;

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign starve_full = (starve_q == CW'(STARVE_MAX));

    // Counts display grants that passed over a waiting host; saturates at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (host_win)
                starve_d = '0;
            else if (disp_req && host_req && !starve_full)
                starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    assign starve_full = 1'b0;
`endif

    assign host_win = host_req && (!disp_req || starve_full);

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        disp_ack_d   = 1'b0;
        disp_rdata_d = disp_rdata_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        case (state_q)
            IDLE: begin
                if (host_win) begin
                    state_d     = H_ISSUE;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                    mem_we_d    = host_we;
                end else if (disp_req) begin
                    state_d    = D_ISSUE;
                    mem_addr_d = disp_addr;
                end
            end
            D_ISSUE: state_d = D_DATA;
            D_DATA: begin
                state_d      = IDLE;
                disp_ack_d   = 1'b1;
                disp_rdata_d = mem_rdata;
            end
            H_ISSUE: state_d = H_DATA;
            H_DATA: begin
                state_d    = IDLE;
                host_ack_d = 1'b1;
                // Write completions leave the last read value visible.
                if (!mem_we_q && !host_we) host_rdata_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            disp_ack_q   <= 1'b0;
            disp_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_ack_q   <= disp_ack_d;
            disp_rdata_q <= disp_rdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_ack   = disp_ack_q;
    assign disp_rdata = disp_rdata_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_vga_mem_arb.sv
// Directed bench for vga_mem_arb with a behavioural synchronous RAM.
module tb_vga_mem_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        disp_req, disp_ack;
    logic [11:0] disp_addr;
    logic [7:0]  disp_rdata;
    logic        host_req, host_we, host_ack;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vga_mem_arb #(.AW(12), .DW(8), .STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        is_disp;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;   // read data, or held host_rdata for writes
    } vec_t;

    vec_t vt [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat = 0;
        int   wecnt = 0;
        logic da = 1'b0, ha = 1'b0;
        logic [7:0] d = 8'h00;
        if (v.is_disp) begin
            disp_req = 1'b1; disp_addr = v.addr;
        end else begin
            host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
        end
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tick();
            if (mem_we) wecnt++;
            if (disp_ack || host_ack) begin
                lat = c; da = disp_ack; ha = host_ack;
                d = v.is_disp ? disp_rdata : host_rdata;
            end
        end
        disp_req = 1'b0;
        host_req = 1'b0;
        chk($sformatf("vec%0d_latency", idx), lat, 3);
        chk($sformatf("vec%0d_ack_route", idx), {da, ha}, v.is_disp ? 2'b10 : 2'b01);
        chk($sformatf("vec%0d_data", idx), d, v.exp);
        chk($sformatf("vec%0d_we_cycles", idx), wecnt, (!v.is_disp && v.we) ? 1 : 0);
        tick();
        chk($sformatf("vec%0d_ack_single", idx), {disp_ack, host_ack}, 2'b00);
    endtask

    initial begin
        int   dcnt, hcnt, last, bad, n;
        logic seq [10];

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h010] = 8'hA5;
        for (int i = 0; i < 4; i++) ram[12'h100 + i] = 8'h40 + 8'(i);

        vt[0] = '{1'b1, 1'b0, 12'h010, 8'h00, 8'hA5};
        vt[1] = '{1'b0, 1'b1, 12'h7FF, 8'h3C, 8'h00};
        vt[2] = '{1'b0, 1'b0, 12'h7FF, 8'h00, 8'h3C};
        vt[3] = '{1'b0, 1'b0, 12'h010, 8'h00, 8'hA5};
        vt[4] = '{1'b0, 1'b1, 12'h000, 8'hFF, 8'hA5};
        vt[5] = '{1'b1, 1'b0, 12'h000, 8'h00, 8'hFF};
        vt[6] = '{1'b0, 1'b1, 12'hFFF, 8'h81, 8'hA5};
        vt[7] = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'h81};
        vt[8] = '{1'b1, 1'b0, 12'h7FF, 8'h00, 8'h3C};

        resetn = 1'b0; disp_req = 1'b0; disp_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #23;
        chk("reset_outputs", {disp_ack, host_ack, mem_we, mem_addr, mem_wdata, disp_rdata, host_rdata}, 0);
        resetn = 1'b1;
        tick();
        chk("reset_idle_outputs", {disp_ack, host_ack, mem_we}, 3'b000);

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Reset while a write sits in H_ISSUE.
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h055; host_wdata = 8'h77;
        tick();
        chk("mid_write_we_high", mem_we, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_reset_async_clear", {disp_ack, host_ack, mem_we}, 3'b000);
        host_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        run_vec(9, vt[0]);

        // Both requesters held continuously.
        disp_req = 1'b1; disp_addr = 12'h010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h123;
        dcnt = 0; hcnt = 0; last = 0; bad = 0; n = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (disp_ack || host_ack) begin
                if (n > 0 && c - last != 3) bad++;
                if (n < 10) seq[n] = host_ack;
                n++;
                last = c;
            end
            if (disp_ack) dcnt++;
            if (host_ack) hcnt++;
        end
        disp_req = 1'b0; host_req = 1'b0;
        chk("contend_ack_spacing", bad, 0);
`ifdef VGA_ARB_STARVE_GUARD_EN
        chk("contend_host_acks", hcnt, 2);
        chk("contend_disp_acks", dcnt, 8);
        for (int i = 0; i < 10; i++)
            chk($sformatf("contend_grant%0d_is_host", i), seq[i], (i % 5) == 4);
`else
        chk("contend_host_acks", hcnt, 0);
        chk("contend_disp_acks", dcnt, 10);
`endif
        for (int i = 0; i < 4; i++) tick();

        // Display held through each ack, new address presented on every ack.
        disp_req = 1'b1; disp_addr = 12'h100;
        n = 0; last = 0; bad = 0;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            tick();
            if (disp_ack) begin
                chk($sformatf("b2b_data%0d", n), disp_rdata, 8'h40 + 8'(n));
                if (n > 0 && c - last != 3) bad++;
                last = c;
                n++;
                if (n == 4) disp_req = 1'b0;
                else        disp_addr = 12'h100 + 12'(n);
            end
        end
        chk("b2b_ack_count", n, 4);
        chk("b2b_spacing", bad, 0);
        tick(); tick(); tick();
        chk("b2b_no_extra_ack", {disp_ack, host_ack}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
